adt_term: RTL and testbench



---
 rtl/adt_term.sv | 150 +++++++++++++++
 tb/tb_adt_term.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adt_term.sv
// adt_term: ADT UART terminal; host writes tx RAM (data_ram/addr_ram/wr_ram) and pulses tx_frame_start to send it on tx (tx_busy), receives rx frames (rx_frame, rx_frame_done, check_sum_error) and flags a missing response (comNoResponse)
module adt_term #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_LEN = 100,
  parameter int RX_LEN = 25,
  parameter int GAP_BITS = 20,
  parameter int RESP_TIMEOUT = 2_500_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  tx_frame_start,
  input  logic [7:0]            data_ram,
  input  logic [15:0]           addr_ram,
  input  logic                  wr_ram,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  rx_frame_done,
  output logic [8*RX_LEN-1:0]   rx_frame,
  output logic                  comNoResponse,
  output logic                  check_sum_error
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int GW = $clog2(GAP_BITS * CLKS_PER_BIT + 1);
  localparam int TW = $clog2(RESP_TIMEOUT);
  localparam int AW = $clog2(TX_LEN);
  localparam int NW = $clog2(RX_LEN);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP_BITS * CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_END = TW'(RESP_TIMEOUT - 1);
  localparam logic [AW-1:0] TX_LAST = AW'(TX_LEN - 1);
  localparam logic [NW-1:0] RX_LAST = NW'(RX_LEN - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;
  logic [7:0] ram [TX_LEN];
  tx_state_t ts, ts_n;
  logic [BW-1:0] tcnt;
  logic [2:0] bit_idx;
  logic [AW-1:0] byte_idx;
  logic [7:0] tsh;
  logic t_tick, tx_end;
  rx_state_t rs, rs_n;
  logic rx_s1, rx_s2;
  logic [BW-1:0] rcnt;
  logic [2:0] rbit;
  logic [7:0] rsh, sum;
  logic [NW-1:0] byte_cnt;
  logic [GW-1:0] idle_cnt;
  logic [8*(RX_LEN-1)-1:0] fsh;
  logic r_tick, mid, byte_ok, frame_end, gap, sum_ok;
  logic timer_on, time_up;
  logic [TW-1:0] resp_cnt;
  always_ff @(posedge clk) begin
    if (wr_ram && addr_ram < 16'(TX_LEN)) ram[addr_ram[AW-1:0]] <= data_ram;
  end
  assign t_tick = tcnt == BIT_LAST;
  assign tx_end = ts == STOP && ts_n == IDLE;
  assign tx = ts == START ? 1'b0 : ts == DATA ? tsh[0] : 1'b1;
  assign tx_busy = ts != IDLE;
  always_comb begin
    ts_n = ts;
    case (ts)
      IDLE:    ts_n = tx_frame_start ? START : IDLE;
      START:   ts_n = t_tick ? DATA : START;
      DATA:    ts_n = (t_tick && bit_idx == 3'd7) ? STOP : DATA;
      STOP:    ts_n = t_tick ? (byte_idx == TX_LAST ? IDLE : START) : STOP;
      default: ts_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts <= IDLE;
      tcnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      tsh <= '0;
    end else begin
      ts <= ts_n;
      tcnt <= (ts == IDLE || t_tick) ? '0 : tcnt + 1'b1;
      if (ts == START && t_tick) tsh <= ram[byte_idx];
      if (ts == DATA && t_tick) begin
        tsh <= tsh >> 1;
        bit_idx <= bit_idx + 1'b1;
      end
      if (ts == STOP && t_tick) byte_idx <= byte_idx + 1'b1;
      if (ts == IDLE) byte_idx <= '0;
    end
  end
  assign r_tick = rcnt == BIT_LAST;
  assign mid = rcnt == HALF;
  assign byte_ok = rs == R_STOP && r_tick && rx_s2;
  assign frame_end = byte_ok && byte_cnt == RX_LAST;
  assign gap = rs == R_IDLE && rx_s2 && idle_cnt == GAP_END;
  assign sum_ok = rsh == sum;
  assign time_up = timer_on && resp_cnt == TO_END;
  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE:  rs_n = rx_s2 ? R_IDLE : R_START;
      R_START: rs_n = mid ? (rx_s2 ? R_IDLE : R_DATA) : R_START;
      R_DATA:  rs_n = (r_tick && rbit == 3'd7) ? R_STOP : R_DATA;
      R_STOP:  rs_n = r_tick ? (rx_s2 ? R_IDLE : R_WAIT) : R_STOP;
      R_WAIT:  rs_n = rx_s2 ? R_IDLE : R_WAIT;
      default: rs_n = R_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rs <= R_IDLE;
      rcnt <= '0;
      rbit <= '0;
      rsh <= '0;
      idle_cnt <= '0;
      byte_cnt <= '0;
      sum <= '0;
      fsh <= '0;
      rx_frame_done <= 1'b0;
      rx_frame <= '0;
      check_sum_error <= 1'b0;
      timer_on <= 1'b0;
      resp_cnt <= '0;
      comNoResponse <= 1'b0;
    end else begin
      {rx_s2, rx_s1} <= {rx_s1, rx};
      rs <= rs_n;
      rcnt <= (rs == R_IDLE || rs == R_WAIT || (rs == R_START && mid) || r_tick) ? '0 : rcnt + 1'b1;
      if (rs == R_DATA && r_tick) begin
        rsh <= {rx_s2, rsh[7:1]};
        rbit <= rbit + 1'b1;
      end
      idle_cnt <= (rs != R_IDLE || !rx_s2) ? '0 : gap ? idle_cnt : idle_cnt + 1'b1;
      if (byte_ok) begin
        fsh <= {fsh[8*RX_LEN-17:0], rsh};
        sum <= byte_cnt == '0 ? rsh : sum + rsh;
        byte_cnt <= frame_end ? '0 : byte_cnt + 1'b1;
      end else if (gap) byte_cnt <= '0;
      rx_frame_done <= frame_end;
      if (frame_end) begin
        rx_frame <= {fsh, rsh};
        check_sum_error <= !sum_ok;
      end
      timer_on <= tx_end ? 1'b1 : (frame_end || time_up) ? 1'b0 : timer_on;
      resp_cnt <= (tx_end || !timer_on) ? '0 : resp_cnt + 1'b1;
      comNoResponse <= (frame_end && sum_ok) ? 1'b0 : (time_up && !frame_end) ? 1'b1 : comNoResponse;
    end
  end
endmodule

// File: tb/tb_adt_term.sv
// tb_adt_term: self-checking bench for adt_term with a cycle-arithmetic tx model and an rx frame scoreboard
module tb_adt_term;
  localparam int CPB = 8, TXL = 100, RXL = 25, RT = 1000, FRAME = TXL * 10 * CPB;
  logic clk = 0, reset_n = 0, rx = 1, tx_frame_start = 0, wr_ram = 0;
  logic [7:0] data_ram = 0;
  logic [15:0] addr_ram = 0;
  logic tx, tx_busy, rx_frame_done, comNoResponse, check_sum_error;
  logic [8*RXL-1:0] rx_frame;
  int nchk = 0, nerr = 0;
  adt_term #(.CLKS_PER_BIT(CPB), .TX_LEN(TXL), .RX_LEN(RXL), .GAP_BITS(20), .RESP_TIMEOUT(RT)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .tx_frame_start(tx_frame_start),
    .data_ram(data_ram), .addr_ram(addr_ram), .wr_ram(wr_ram),
    .tx(tx), .tx_busy(tx_busy), .rx_frame_done(rx_frame_done), .rx_frame(rx_frame),
    .comNoResponse(comNoResponse), .check_sum_error(check_sum_error)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [199:0] act, input logic [199:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  int cyc = 0;
  logic rst_q = 1, wr_q = 0, start_q = 0;
  logic [15:0] addr_q = 0;
  logic [7:0] data_q = 0;
  always @(posedge clk) begin
    cyc++;
    rst_q = !reset_n;
    wr_q = wr_ram;
    start_q = tx_frame_start;
    addr_q = addr_ram;
    data_q = data_ram;
  end
  logic [7:0] mram [TXL];
  logic mbusy = 0, mtimer = 0, mflag = 0, mcs = 0, prev_done = 0, check_on = 0;
  logic [8*RXL-1:0] mframe = '0;
  int tstart = 0, tend = 0, n_got = 0, n_exp = 0;
  logic [8*RXL-1:0] exp_frame [8];
  logic exp_cs [8];
  always @(negedge clk) begin
    int t, bp;
    logic etx;
    if (wr_q && addr_q < TXL) mram[addr_q] = data_q;
    if (rst_q) begin
      mbusy = 0; mtimer = 0; mflag = 0; mcs = 0; mframe = '0;
    end else begin
      if (mbusy && cyc - tstart == FRAME) begin mbusy = 0; mtimer = 1; tend = cyc; end
      else if (!mbusy && start_q) begin mbusy = 1; tstart = cyc; end
      if (rx_frame_done) begin
        check("frame expected by scoreboard", n_got < n_exp, 1);
        if (n_got < n_exp) begin mframe = exp_frame[n_got]; mcs = exp_cs[n_got]; end
        n_got++;
        mtimer = 0;
        if (!mcs) mflag = 0;
      end
      if (mtimer && cyc - tend == RT) begin mflag = 1; mtimer = 0; end
    end
    t = cyc - tstart;
    bp = (t / CPB) % 10;
    etx = !mbusy ? 1'b1 : bp == 0 ? 1'b0 : bp == 9 ? 1'b1 : mram[t / (10 * CPB)][bp - 1];
    if (check_on) begin
      check("tx", tx, etx);
      check("tx_busy", tx_busy, mbusy);
      check("comNoResponse", comNoResponse, mflag);
      check("check_sum_error", check_sum_error, mcs);
      check("rx_frame", rx_frame, mframe);
      if (prev_done) check("rx_frame_done width", rx_frame_done, 0);
    end
    prev_done = rx_frame_done;
  end
  logic [7:0] dec [256];
  logic [9:0] dbits = '0;
  int nd = 0, dcnt = 0;
  logic dact = 0;
  always @(negedge clk) begin
    if (!reset_n) dact = 0;
    else if (!dact) begin
      if (tx === 1'b0) begin dact = 1; dcnt = 0; end
    end else dcnt++;
    if (dact && dcnt % CPB == CPB / 2) begin
      dbits[dcnt / CPB] = tx;
      if (dcnt / CPB == 9) begin
        check("tx start bit", dbits[0], 0);
        check("tx stop bit", dbits[9], 1);
        dec[nd] = dbits[8:1];
        nd++;
        dact = 0;
      end
    end
  end
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input int a, input logic [7:0] d);
    addr_ram = 16'(a); data_ram = d; wr_ram = 1;
    tick(2);
    wr_ram = 0;
    tick(1);
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx = 0; tick(CPB);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
    rx = 1; tick(CPB);
  endtask
  task automatic send_frame(input logic [7:0] fb [RXL]);
    logic [8*RXL-1:0] f = '0;
    logic [7:0] s = 0;
    for (int i = 0; i < RXL; i++) begin
      f = {f[8*RXL-9:0], fb[i]};
      if (i < RXL - 1) s += fb[i];
    end
    exp_frame[n_exp] = f;
    exp_cs[n_exp] = s != fb[RXL-1];
    n_exp++;
    for (int i = 0; i < RXL; i++) send_byte(fb[i]);
  endtask
  task automatic wait_busy_low(input string nm, output int n);
    n = 0;
    while (tx_busy && n < FRAME + 100) begin tick(1); n++; end
    check(nm, tx_busy, 0);
  endtask
  task automatic wait_flag(output int n);
    n = 0;
    while (!comNoResponse && n < RT + 100) begin tick(1); n++; end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] fb [RXL];
    int n, b0, d0;
    tick(3);
    check_on = 1;
    check("reset tx", tx, 1);
    check("reset tx_busy", tx_busy, 0);
    check("reset rx_frame_done", rx_frame_done, 0);
    check("reset rx_frame", rx_frame, 0);
    check("reset comNoResponse", comNoResponse, 0);
    check("reset check_sum_error", check_sum_error, 0);
    reset_n = 1;
    rx = 0;
    wr(0, 8'hEE);
    for (int i = 1; i < 10; i++) wr(i, 8'(8'h11 * (i + 1)));
    for (int i = 10; i < 57; i++) wr(i, 8'h55);
    for (int i = 57; i < 67; i++) wr(i, 8'(8'h57 + i - 57));
    for (int i = 67; i < 97; i++) wr(i, 8'h55);
    for (int i = 97; i < 100; i++) wr(i, 8'(8'h97 + i - 97));
    wr(100, 8'hFF);
    wr(16'hFFFF, 8'hFF);
    b0 = nd; d0 = n_got;
    addr_ram = 0; data_ram = 8'h11; wr_ram = 1; tx_frame_start = 1;
    tick(1);
    wr_ram = 0; tx_frame_start = 0;
    wait_busy_low("tx frame 1 ends", n);
    check("tx_busy duration", n, FRAME);
    wait_flag(n);
    check("noresp delay", n, RT);
    check("no rx frames while rx low", n_got - d0, 0);
    check("tx bytes decoded", nd - b0, TXL);
    check("tx byte 0", dec[b0], 8'h11);
    check("tx byte 9", dec[b0 + 9], 8'hAA);
    check("tx byte 57", dec[b0 + 57], 8'h57);
    check("tx byte 99", dec[b0 + 99], 8'h99);
    rx = 1;
    tick(4 * CPB);
    d0 = n_got;
    for (int i = 0; i < RXL - 1; i++) fb[i] = 8'(i + 1);
    fb[RXL-1] = 8'h2C;
    send_frame(fb);
    tick(CPB);
    check("good frame count", n_got - d0, 1);
    check("good frame byte0", rx_frame[199:192], 8'h01);
    check("good frame byte24", rx_frame[7:0], 8'h2C);
    check("good frame checksum", check_sum_error, 0);
    check("good frame clears noresp", comNoResponse, 0);
    tx_frame_start = 1;
    tick(1);
    tx_frame_start = 0;
    wait_busy_low("tx frame 2 ends", n);
    wait_flag(n);
    check("noresp after frame 2", comNoResponse, 1);
    d0 = n_got;
    fb[RXL-1] = 8'h2D;
    send_frame(fb);
    tick(CPB);
    check("bad frame count", n_got - d0, 1);
    check("bad frame byte24", rx_frame[7:0], 8'h2D);
    check("bad frame checksum", check_sum_error, 1);
    check("bad frame keeps noresp", comNoResponse, 1);
    rx = 0; tick(2); rx = 1; tick(2 * CPB);
    d0 = n_got;
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i));
    tick(25 * CPB);
    for (int i = 0; i < RXL - 1; i++) fb[i] = 8'(8'h40 + i);
    fb[RXL-1] = 8'h14;
    send_frame(fb);
    tick(CPB);
    check("gap frame count", n_got - d0, 1);
    check("gap frame byte0", rx_frame[199:192], 8'h40);
    check("gap frame byte24", rx_frame[7:0], 8'h14);
    check("gap frame checksum", check_sum_error, 0);
    check("gap frame clears noresp", comNoResponse, 0);
    tx_frame_start = 1;
    tick(1);
    tx_frame_start = 0;
    tick(500);
    check("busy before mid reset", tx_busy, 1);
    reset_n = 0;
    tick(2);
    check("mid reset tx", tx, 1);
    check("mid reset tx_busy", tx_busy, 0);
    check("mid reset rx_frame", rx_frame, 0);
    check("mid reset check_sum_error", check_sum_error, 0);
    check("mid reset comNoResponse", comNoResponse, 0);
    reset_n = 1;
    tick(5 * CPB);
    check("frames seen", n_got, n_exp);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
